// File: rtl/fifo_sync_sram_pkg.sv
// Shared constants and helpers for the SRAM-backed synchronous FIFO.
//   clog2       : constant ceiling-log2 used for derived widths
//   RD_LAT_MIN/ : legal range of the SRAM read latency
//   RD_LAT_MAX
//   PF_EXTRA    : prefetch entries beyond the read latency (PF_DEPTH = RD_LAT + PF_EXTRA)
package fifo_sync_sram_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int PF_EXTRA   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_pf_buf.sv
// Small register FIFO used as the prefetch / output stage.
// Entry 0 is the head and is a plain register, so head is registered.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous flush (same effect as rst)
//   wr_en      : append wr_data (caller guarantees space after any same-cycle read)
//   wr_data    : word to append
//   rd_en      : drop the head (caller guarantees cnt != 0)
//   head       : current head word; held when the last word is consumed
//   cnt        : number of valid entries
module fifo_pf_buf
  import fifo_sync_sram_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int PF_DEPTH = 3,
  localparam int PCW     = clog2(PF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] head,
  output logic [PCW-1:0]    cnt
);

  logic [DATA_W-1:0] mem [PF_DEPTH];
  logic [DATA_W-1:0] shift_src [PF_DEPTH];
  logic [PCW-1:0]    wr_idx;
  logic              shift;

  for (genvar i = 0; i < PF_DEPTH; i++) begin : g_src
    if (i == PF_DEPTH - 1) begin : g_last
      assign shift_src[i] = mem[i];
    end else begin : g_mid
      assign shift_src[i] = mem[i + 1];
    end
  end

  // Popping the only word keeps the head register as-is, so the output
  // does not change while the buffer sits empty.
  assign shift  = rd_en && (cnt != PCW'(1));
  assign wr_idx = rd_en ? cnt - PCW'(1) : cnt;
  assign head   = mem[0];

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else            cnt <= cnt + PCW'(wr_en) - PCW'(rd_en);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PF_DEPTH; i++) begin
      if (wr_en && (wr_idx == PCW'(i))) mem[i] <= wr_data;
      else if (shift)                   mem[i] <= shift_src[i];
    end
    if (rst || clr) mem[0] <= '0;
  end

endmodule

// File: rtl/fifo_sync_sram_pf.sv
// Synchronous FIFO backed by an external SRAM macro with a credit-controlled
// prefetch buffer, empty-FIFO bypass, flush with in-flight read discard and a
// programmable almost-full threshold.
// Optional statistics (fifo_ovf, fifo_udf, fifo_wmark) are built when the
// macro FIFO_SRAM_STAT_EN is defined; otherwise they are tied to 0.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   fifo_init       : synchronous flush; push/pop in that cycle are ignored
//   fifo_push       : write strobe with fifo_data_in
//   fifo_full/afull : SRAM occupancy == DEPTH / >= AFULL_TH
//   fifo_pop        : consume fifo_data_out (ignored when fifo_empty)
//   fifo_data_out   : registered head word; fifo_empty = no word at output
//   fifo_word_cnt   : words held in SRAM + in flight + prefetch
//   sram_*          : SRAM macro interface, sram_rdata valid RD_LAT cycles after sram_re
//   fifo_ovf/udf    : sticky overflow / underflow flags
//   fifo_wmark      : peak SRAM occupancy since last clear
module fifo_sync_sram_pf
  import fifo_sync_sram_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int DEPTH    = 64,
  parameter int RD_LAT   = 1,
  parameter int SRAM_1RW = 1,
  parameter int AFULL_TH = DEPTH - 2,
  localparam int PF_DEPTH = RD_LAT + PF_EXTRA,
  localparam int AW       = clog2(DEPTH),
  localparam int CW       = clog2(DEPTH + PF_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_init,
  input  logic              fifo_push,
  input  logic [DATA_W-1:0] fifo_data_in,
  output logic              fifo_full,
  output logic              fifo_afull,
  input  logic              fifo_pop,
  output logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_empty,
  output logic [CW-1:0]     fifo_word_cnt,
  output logic              sram_re,
  output logic              sram_we,
  output logic [AW-1:0]     sram_raddr,
  output logic [AW-1:0]     sram_waddr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              fifo_ovf,
  output logic              fifo_udf,
  output logic [AW:0]       fifo_wmark
);

  localparam int PCW = clog2(PF_DEPTH + 1);
  localparam logic [PCW-1:0] PF_FULL   = PCW'(PF_DEPTH);
  localparam logic [AW:0]    AFULL_LVL = (AW + 1)'(AFULL_TH);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("fifo_sync_sram_pf: RD_LAT must be within 1..3");
  end

  logic [AW:0]       wptr, rptr, sram_cnt;
  logic              sram_empty;
  logic [RD_LAT-1:0] rd_vld_p;
  logic [PCW-1:0]    inflight, pf_cnt, pf_post, drop_cnt;
  logic              push_ok, pop_acc, bypass, push_acc, credit_ok;
  logic              ret_vld, ret_keep, pf_wr;
  logic [DATA_W-1:0] pf_wdata;

  assign sram_cnt   = wptr - rptr;
  assign sram_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign fifo_afull = (sram_cnt >= AFULL_LVL);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + PCW'(rd_vld_p[i]);
  end

  // Request side: pop is resolved first so bypass sees the post-pop buffer.
  assign fifo_empty = (pf_cnt == '0);
  assign push_ok    = fifo_push && !fifo_init;
  assign pop_acc    = fifo_pop && !fifo_init && !fifo_empty;
  assign pf_post    = pf_cnt - PCW'(pop_acc);
  assign bypass     = push_ok && sram_empty && (inflight == '0) && (pf_post < PF_FULL);
  assign sram_we    = push_ok && !bypass && !fifo_full;
  assign push_acc   = bypass || sram_we;

  // Credit counts words already buffered plus reads still returning, so the
  // prefetch buffer can never overflow.
  assign credit_ok  = ({1'b0, pf_cnt} + {1'b0, inflight}) < {1'b0, PF_FULL};
  assign sram_re    = !fifo_init && !sram_empty && credit_ok && !((SRAM_1RW != 0) && sram_we);

  assign sram_waddr = wptr[AW-1:0];
  assign sram_raddr = rptr[AW-1:0];
  assign sram_wdata = fifo_data_in;

  always_ff @(posedge clk) begin
    if (rst || fifo_init) begin
      wptr          <= '0;
      rptr          <= '0;
      fifo_word_cnt <= '0;
    end else begin
      wptr          <= wptr + (AW + 1)'(sram_we);
      rptr          <= rptr + (AW + 1)'(sram_re);
      fifo_word_cnt <= fifo_word_cnt + CW'(push_acc) - CW'(pop_acc);
    end
  end

  // Read pipeline: rd_vld_p[k] marks a read issued k+1 cycles ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_p <= '0;
    end else begin
      rd_vld_p[0] <= sram_re;
      for (int i = 1; i < RD_LAT; i++) rd_vld_p[i] <= rd_vld_p[i - 1];
    end
  end

  assign ret_vld = rd_vld_p[RD_LAT-1];

  // Reads issued before a flush keep returning; the drop counter swallows
  // exactly those. The one landing in the flush cycle dies with the buffer.
  always_ff @(posedge clk) begin
    if (rst)                               drop_cnt <= '0;
    else if (fifo_init)                    drop_cnt <= inflight - PCW'(ret_vld);
    else if (ret_vld && (drop_cnt != '0))  drop_cnt <= drop_cnt - PCW'(1);
  end

  assign ret_keep = ret_vld && (drop_cnt == '0);

  // Prefetch / output stage: bypass and SRAM returns are mutually exclusive
  // because bypass requires nothing in flight.
  assign pf_wr    = bypass || ret_keep;
  assign pf_wdata = bypass ? fifo_data_in : sram_rdata;

  fifo_pf_buf #(
    .DATA_W   (DATA_W),
    .PF_DEPTH (PF_DEPTH)
  ) u_pf_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (fifo_init),
    .wr_en   (pf_wr),
    .wr_data (pf_wdata),
    .rd_en   (pop_acc),
    .head    (fifo_data_out),
    .cnt     (pf_cnt)
  );

`ifdef FIFO_SRAM_STAT_EN
  logic        ovf_q, udf_q;
  logic [AW:0] wmark_q;

  always_ff @(posedge clk) begin
    if (rst || fifo_init) begin
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      wmark_q <= '0;
    end else begin
      if (push_ok && !bypass && fifo_full)    ovf_q   <= 1'b1;
      if (fifo_pop && fifo_empty)             udf_q   <= 1'b1;
      if (sram_cnt > wmark_q)                 wmark_q <= sram_cnt;
    end
  end

  assign fifo_ovf   = ovf_q;
  assign fifo_udf   = udf_q;
  assign fifo_wmark = wmark_q;
`else
  assign fifo_ovf   = 1'b0;
  assign fifo_udf   = 1'b0;
  assign fifo_wmark = '0;
`endif

endmodule

// File: tb/tb_fifo_sync_sram_pf.sv
// Directed bench for fifo_sync_sram_pf.
// Instance A: RD_LAT=3, 1R1W macro (bypass, underflow, afull, streaming, flush).
// Instance B: RD_LAT=2, single-port macro (fill/overflow, read/write conflict).
module tb_fifo_sync_sram_pf;

`ifdef FIFO_SRAM_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  // ---------------- instance A signals ----------------
  logic        a_init, a_push, a_pop, a_full, a_afull, a_empty, a_re, a_we, a_ovf, a_udf;
  logic [31:0] a_din, a_dout, a_wdata, a_rdata;
  logic [7:0]  a_cnt;
  logic [5:0]  a_raddr, a_waddr;
  logic [6:0]  a_wmark;
  logic [31:0] a_mem [64];
  logic [31:0] a_pipe [3];
  int          a_we_cnt = 0;
  logic [31:0] qa [$];

  // ---------------- instance B signals ----------------
  logic        b_init, b_push, b_pop, b_full, b_afull, b_empty, b_re, b_we, b_ovf, b_udf;
  logic [31:0] b_din, b_dout, b_wdata, b_rdata;
  logic [7:0]  b_cnt;
  logic [5:0]  b_raddr, b_waddr;
  logic [6:0]  b_wmark;
  logic [31:0] b_mem [64];
  logic [31:0] b_pipe [2];
  int          b_re_cnt = 0, b_we_cnt = 0, b_conf = 0;
  logic [31:0] qb [$];

  fifo_sync_sram_pf #(.DATA_W(32), .DEPTH(64), .RD_LAT(3), .SRAM_1RW(0)) u_dut_a (
    .clk(clk), .rst(rst), .fifo_init(a_init), .fifo_push(a_push), .fifo_data_in(a_din),
    .fifo_full(a_full), .fifo_afull(a_afull), .fifo_pop(a_pop), .fifo_data_out(a_dout),
    .fifo_empty(a_empty), .fifo_word_cnt(a_cnt), .sram_re(a_re), .sram_we(a_we),
    .sram_raddr(a_raddr), .sram_waddr(a_waddr), .sram_wdata(a_wdata), .sram_rdata(a_rdata),
    .fifo_ovf(a_ovf), .fifo_udf(a_udf), .fifo_wmark(a_wmark)
  );

  fifo_sync_sram_pf #(.DATA_W(32), .DEPTH(64), .RD_LAT(2), .SRAM_1RW(1)) u_dut_b (
    .clk(clk), .rst(rst), .fifo_init(b_init), .fifo_push(b_push), .fifo_data_in(b_din),
    .fifo_full(b_full), .fifo_afull(b_afull), .fifo_pop(b_pop), .fifo_data_out(b_dout),
    .fifo_empty(b_empty), .fifo_word_cnt(b_cnt), .sram_re(b_re), .sram_we(b_we),
    .sram_raddr(b_raddr), .sram_waddr(b_waddr), .sram_wdata(b_wdata), .sram_rdata(b_rdata),
    .fifo_ovf(b_ovf), .fifo_udf(b_udf), .fifo_wmark(b_wmark)
  );

  // SRAM macro models: data appears RD_LAT cycles after the read enable.
  always @(posedge clk) begin
    if (a_we) a_mem[a_waddr] <= a_wdata;
    a_pipe[0] <= a_re ? a_mem[a_raddr] : 32'hDEAD_BEEF;
    a_pipe[1] <= a_pipe[0];
    a_pipe[2] <= a_pipe[1];
    if (a_we) a_we_cnt <= a_we_cnt + 1;
  end
  assign a_rdata = a_pipe[2];

  always @(posedge clk) begin
    if (b_we) b_mem[b_waddr] <= b_wdata;
    b_pipe[0] <= b_re ? b_mem[b_raddr] : 32'hDEAD_BEEF;
    b_pipe[1] <= b_pipe[0];
    if (b_re) b_re_cnt <= b_re_cnt + 1;
    if (b_we) b_we_cnt <= b_we_cnt + 1;
    if (b_re && b_we) b_conf <= b_conf + 1;
  end
  assign b_rdata = b_pipe[1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus on A; an accepted pop is checked against the model queue.
  task automatic cyc_a(input logic push, input logic [31:0] d, input logic pop, input logic init);
    logic [31:0] exp;
    a_push = push; a_din = d; a_pop = pop; a_init = init;
    #1;
    if (pop && !init && !a_empty) begin
      exp = (qa.size() != 0) ? qa.pop_front() : 32'hBAD0_BAD0;
      check("a_pop_data", 64'(a_dout), 64'(exp));
    end
    if (push && !init) qa.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic cyc_b(input logic push, input logic [31:0] d, input logic pop, input logic keep);
    logic [31:0] exp;
    b_push = push; b_din = d; b_pop = pop; b_init = 1'b0;
    #1;
    if (pop && !b_empty) begin
      exp = (qb.size() != 0) ? qb.pop_front() : 32'hBAD0_BAD0;
      check("b_pop_data", 64'(b_dout), 64'(exp));
    end
    if (push && keep) qb.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic drain_a(input int budget);
    for (int i = 0; i < budget && qa.size() != 0; i++) cyc_a(1'b0, 32'd0, 1'b1, 1'b0);
    a_pop = 1'b0;
    check("a_drain_left", 64'(qa.size()), 64'd0);
    check("a_drain_empty", 64'(a_empty), 64'd1);
  endtask

  task automatic drain_b(input int budget);
    for (int i = 0; i < budget && qb.size() != 0; i++) cyc_b(1'b0, 32'd0, 1'b1, 1'b0);
    b_pop = 1'b0;
    check("b_drain_left", 64'(qb.size()), 64'd0);
    check("b_drain_empty", 64'(b_empty), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0, r0, c0;
    rst = 1'b1;
    a_init = 0; a_push = 0; a_pop = 0; a_din = '0;
    b_init = 0; b_push = 0; b_pop = 0; b_din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_empty", 64'(a_empty), 64'd1);
    check("rst_full",  64'(a_full),  64'd0);
    check("rst_afull", 64'(a_afull), 64'd0);
    check("rst_cnt",   64'(a_cnt),   64'd0);
    check("rst_re",    64'(a_re),    64'd0);
    check("rst_we",    64'(a_we),    64'd0);
    check("rst_dout",  64'(a_dout),  64'd0);
    check("rst_ovf",   64'(a_ovf),   64'd0);
    check("rst_udf",   64'(a_udf),   64'd0);
    check("rst_wmark", 64'(a_wmark), 64'd0);
    check("rst_b_empty", 64'(b_empty), 64'd1);
    check("rst_b_cnt",   64'(b_cnt),   64'd0);

    // Single push through the bypass path
    w0 = a_we_cnt;
    cyc_a(1'b1, 32'hA5, 1'b0, 1'b0);
    check("byp_empty", 64'(a_empty), 64'd0);
    check("byp_cnt1",  64'(a_cnt),   64'd1);
    check("byp_dout",  64'(a_dout),  64'hA5);
    cyc_a(1'b0, 32'd0, 1'b1, 1'b0);
    check("byp_cnt0",  64'(a_cnt),   64'd0);
    check("byp_empty1", 64'(a_empty), 64'd1);
    check("byp_no_we", 64'(a_we_cnt - w0), 64'd0);

    // Underflow: pop while empty is ignored
    cyc_a(1'b0, 32'd0, 1'b1, 1'b0);
    check("udf_flag", 64'(a_udf), 64'(STAT));
    check("udf_dout", 64'(a_dout), 64'hA5);
    check("udf_cnt",  64'(a_cnt),  64'd0);

    // Almost-full: 5 words bypass into prefetch, the rest sit in SRAM
    for (int i = 0; i < 67; i++) begin
      cyc_a(1'b1, 32'h100 + i, 1'b0, 1'b0);
      if (i == 65) check("afull_61", 64'(a_afull), 64'd0);
    end
    a_push = 1'b0;
    check("afull_62",   64'(a_afull), 64'd1);
    check("afull_cnt",  64'(a_cnt),   64'd67);
    check("afull_full", 64'(a_full),  64'd0);
    drain_a(300);
    check("wmark_62", 64'(a_wmark), STAT ? 64'd62 : 64'd0);

    // Flush clears statistics
    cyc_a(1'b0, 32'd0, 1'b0, 1'b1);
    qa.delete();
    check("init_udf",   64'(a_udf),   64'd0);
    check("init_wmark", 64'(a_wmark), 64'd0);

    // Streaming: 20 preloaded words, then push+pop every cycle without bubbles
    for (int i = 0; i < 20; i++) cyc_a(1'b1, 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc_a(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      check("stream_bubble", 64'(a_empty), 64'd0);
      cyc_a(1'b1, 32'(20 + i), 1'b1, 1'b0);
    end
    a_push = 1'b0;
    drain_a(300);

    // Flush with three reads in flight
    for (int i = 0; i < 10; i++) cyc_a(1'b1, 32'h200 + i, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)  cyc_a(1'b0, 32'd0, 1'b1, 1'b0);
    cyc_a(1'b0, 32'd0, 1'b0, 1'b1);
    qa.delete();
    check("flush_cnt",   64'(a_cnt),   64'd0);
    check("flush_empty", 64'(a_empty), 64'd1);
    check("flush_dout",  64'(a_dout),  64'd0);
    cyc_a(1'b1, 32'h55, 1'b0, 1'b0);
    for (int i = 0; i < 20 && a_empty; i++) cyc_a(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc_a(1'b0, 32'd0, 1'b0, 1'b0);
    check("flush_ready", 64'(a_empty), 64'd0);
    check("flush_first", 64'(a_dout),  64'h55);
    check("flush_cnt1",  64'(a_cnt),   64'd1);
    cyc_a(1'b0, 32'd0, 1'b1, 1'b0);
    a_pop = 1'b0;
    check("flush_done", 64'(a_empty), 64'd1);

    // B: fill to DEPTH + PF_DEPTH (64 + 4), then one dropped push
    for (int i = 0; i < 68; i++) begin
      if (i == 67) check("fill_not_full", 64'(b_full), 64'd0);
      cyc_b(1'b1, 32'h300 + i, 1'b0, 1'b1);
    end
    b_push = 1'b0;
    check("fill_full",  64'(b_full),  64'd1);
    check("fill_afull", 64'(b_afull), 64'd1);
    check("fill_cnt",   64'(b_cnt),   64'd68);
    b_push = 1'b1; b_din = 32'h3FF;
    #1;
    check("ovf_no_we", 64'(b_we), 64'd0);
    @(posedge clk); #1;
    b_push = 1'b0;
    check("ovf_cnt",  64'(b_cnt),  64'd68);
    check("ovf_flag", 64'(b_ovf),  64'(STAT));
    drain_b(400);

    // B: single-port conflict, alternating pushes under continuous pop
    for (int i = 0; i < 12; i++) cyc_b(1'b1, 32'h400 + i, 1'b0, 1'b1);
    w0 = b_we_cnt; r0 = b_re_cnt; c0 = b_conf;
    for (int i = 0; i < 40; i++) cyc_b((i % 2) == 0, 32'h500 + i, 1'b1, (i % 2) == 0);
    b_push = 1'b0;
    drain_b(200);
    check("rw_conflict", 64'(b_conf - c0), 64'd0);
    check("rw_we_seen",  64'((b_we_cnt - w0) > 0), 64'd1);
    check("rw_re_seen",  64'((b_re_cnt - r0) > 0), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_sync_sram_pf.md
Name: fifo_sync_sram_pf

Overview:
- Next-generation synchronous FIFO backed by an external single- or dual-port SRAM macro.
- Adds a parametrised SRAM read latency, a credit-controlled prefetch buffer, empty-FIFO bypass, flush with in-flight read discard, and a programmable almost-full threshold.
- Sits in the iDMA read/write data paths between the NoC interface and the 128b datapath. Drop-in successor of the fixed-latency SRAM FIFO.

Parameters:
- DATA_W, 128, data word width
- DEPTH, 64, SRAM entries; must be a power of 2, at least 4
- RD_LAT, 1, SRAM read latency in cycles from sram_re to sram_rdata valid; legal range 1..3
- SRAM_1RW, 1, 1 = single-port macro (no read in a write cycle); 0 = 1R1W macro
- AFULL_TH, DEPTH-2, SRAM occupancy at or above which fifo_afull asserts
- PF_DEPTH, RD_LAT+2, prefetch buffer entries (derived; not overridden)
- AW, $clog2(DEPTH), SRAM address width (derived)
- CW, $clog2(DEPTH+PF_DEPTH)+1, total-count width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- fifo_init  in  1  synchronous flush
- fifo_push  in  1  write strobe
- fifo_data_in  in  DATA_W  write data
- fifo_full  out  1  SRAM occupancy == DEPTH
- fifo_afull  out  1  SRAM occupancy >= AFULL_TH
- fifo_pop  in  1  read strobe; consumes fifo_data_out
- fifo_data_out  out  DATA_W  head word (registered)
- fifo_empty  out  1  no word at output
- fifo_word_cnt  out  CW  words held: SRAM + in-flight + prefetch
- sram_re  out  1  SRAM read enable
- sram_we  out  1  SRAM write enable
- sram_raddr  out  AW  read address
- sram_waddr  out  AW  write address
- sram_wdata  out  DATA_W  write data
- sram_rdata  in  DATA_W  read data, valid RD_LAT cycles after sram_re
- fifo_ovf  out  1  sticky overflow flag (see Optional Feature)
- fifo_udf  out  1  sticky underflow flag (see Optional Feature)
- fifo_wmark  out  AW+1  peak SRAM occupancy (see Optional Feature)

Behaviour:
- Reset and init: rst or fifo_init clears both pointers, SRAM count, prefetch buffer and stats. Outputs after reset: fifo_empty=1, fifo_full=0, fifo_afull=0, fifo_word_cnt=0, sram_re=0, sram_we=0, data_out=0.
- Init discard: on fifo_init, the in-flight read count (0..RD_LAT) is loaded into a drop counter. Returning rdata is discarded while the drop counter is non-zero.
- Pointers: AW+1 bits; wrap at DEPTH. Full = MSBs differ and low bits equal. Empty = pointers equal.
- Bypass: fifo_push while SRAM empty, in-flight == 0 and prefetch not full writes the word directly into the prefetch buffer; sram_we=0. fifo_empty drops the next cycle.
- SRAM write: otherwise sram_we = fifo_push && !full. A push when full is dropped; the data is lost and fifo_ovf is set.
- Read credit: sram_re = SRAM non-empty && (pf_cnt + inflight) < PF_DEPTH && !(SRAM_1RW && sram_we). This sustains one word per cycle with continuous pop.
- In-flight tracking: RD_LAT-stage valid shift register. Returning data is written into the prefetch buffer in order.
- Latency, push to fifo_empty=0 when bypassing: 1 cycle. Via SRAM: RD_LAT+2 cycles, blocked reads excluded.
- Pop: fifo_pop with fifo_empty=1 is ignored and sets fifo_udf. Pop and an incoming word in the same cycle are both legal.
- Simultaneous push and pop when word_cnt==1 at the output: bypass is used only if the bypass conditions hold after the pop.
- fifo_word_cnt: updated every cycle by +push_accepted −pop_accepted. It never exceeds DEPTH+PF_DEPTH.
- Write side never stalls on the read side; SRAM_1RW gives writes priority.

Optional Feature:
- Macro: FIFO_SRAM_STAT_EN.
- Defined: fifo_ovf and fifo_udf are sticky, cleared by rst or fifo_init. fifo_wmark holds the maximum SRAM occupancy since the last clear.
- Undefined: all three outputs are tied to 0 and no stat registers are synthesised.

Decomposition:
- Package fifo_sync_sram_pkg: clog2 function, RD_LAT legality bounds, PF_DEPTH derivation constant.
- Sub-module fifo_pf_buf: a PF_DEPTH-entry register FIFO with count output and registered head. It is instantiated once as the prefetch/output stage.
- Top level holds the pointers, credit logic, in-flight shift register, bypass mux and stats.

Test Plan:
- Reset, single push: push 0xA5 into an empty FIFO -> fifo_empty=0 next cycle; sram_we never asserts; pop returns 0xA5; word_cnt goes 1 -> 0.
- Fill and overflow: DEPTH=64, RD_LAT=2, no pops, push 64+PF_DEPTH+1 words -> fifo_full=1 and the last push is dropped. Draining returns all words in order; fifo_ovf=1 when STAT_EN is defined.
- Streaming throughput: RD_LAT=3, SRAM_1RW=0, continuous push and pop of 1000 incrementing words after 20 words are preloaded -> zero bubbles on output; order is preserved.
- 1RW conflict: SRAM_1RW=1, alternate push/no-push with continuous pop -> sram_re never coincides with sram_we; no data loss.
- Flush mid-flight: RD_LAT=3, assert fifo_init while 3 reads are in flight -> no stale word appears; word_cnt=0. The next pushed word 0x55 is the first popped.
- Underflow and afull: pop on an empty FIFO -> fifo_udf=1 and output unchanged. Push until SRAM occupancy = AFULL_TH=62 -> fifo_afull rises in the same cycle the count reaches 62.
